// File: rtl/led_pattern_driver_pkg.sv
// Shared definitions for the multi-channel LED pattern driver.
// Mode encodings and the boot-time blink half-period table.
package led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'd0;
    localparam mode_t MODE_ON      = 2'd1;
    localparam mode_t MODE_BLINK   = 2'd2;
    localparam mode_t MODE_BREATHE = 2'd3;

    // Staggered boot blink rates: 40, 80, 120 ... ticks, clipped to the counter range.
    function automatic int boot_arg(input int idx, input int bits);
        int max_v;
        int a;
        max_v = (32'sd1 << bits) - 32'sd1;
        a     = 32'sd40 * (idx + 32'sd1);
        return (a > max_v) ? max_v : a;
    endfunction

endpackage

// File: rtl/led_pattern_driver_channel.sv
// One LED channel: holds its mode/arg and tick-driven pattern state,
// and reports whether the LED is lit for the current PWM count.
module led_channel
    import led_pkg::*;
#(
    parameter int                     PWM_BITS  = 8,
    parameter mode_t                  BOOT_MODE = MODE_OFF,
    parameter logic [PWM_BITS-1:0]    BOOT_ARG  = {PWM_BITS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                wr_en,
    input  mode_t               wr_mode,
    input  logic [PWM_BITS-1:0] wr_arg,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                lit
);

    localparam int                  CW   = PWM_BITS + 1;
    localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] BOOT_LEVEL = (BOOT_MODE == MODE_BLINK) ? MAX : ZERO;

    mode_t               mode_q,   mode_d;
    logic [PWM_BITS-1:0] arg_q,    arg_d;
    logic [PWM_BITS-1:0] tcnt_q,   tcnt_d;
    logic                bstate_q, bstate_d;
    logic [PWM_BITS-1:0] level_q,  level_d;
    logic                dir_q,    dir_d;
    logic [PWM_BITS-1:0] arg_eff_s;
    logic                step_s;

    // Next-state: a config write wins over a coincident tick.
    always_comb begin
        mode_d    = mode_q;
        arg_d     = arg_q;
        tcnt_d    = tcnt_q;
        bstate_d  = bstate_q;
        level_d   = level_q;
        dir_d     = dir_q;
        arg_eff_s = (arg_q == ZERO) ? ONE : arg_q;
        step_s    = ({1'b0, tcnt_q} + CW'(1)) >= {1'b0, arg_eff_s};
        if (wr_en) begin
            mode_d   = wr_mode;
            arg_d    = wr_arg;
            tcnt_d   = ZERO;
            bstate_d = 1'b1;
            dir_d    = 1'b1;
            case (wr_mode)
                MODE_ON:    level_d = wr_arg;
                MODE_BLINK: level_d = MAX;
                default:    level_d = ZERO;
            endcase
        end else if (tick && (mode_q == MODE_BLINK)) begin
            if (step_s) begin
                tcnt_d   = ZERO;
                bstate_d = ~bstate_q;
                level_d  = bstate_q ? ZERO : MAX;
            end else begin
                tcnt_d = tcnt_q + ONE;
            end
        end else if (tick && (mode_q == MODE_BREATHE)) begin
            if (!step_s) begin
                tcnt_d = tcnt_q + ONE;
            end else begin
                tcnt_d = ZERO;
                if (dir_q) begin
                    if (level_q == MAX) begin
                        dir_d   = 1'b0;
                        level_d = MAX - ONE;
                    end else begin
                        level_d = level_q + ONE;
                    end
                end else begin
                    if (level_q == ZERO) begin
                        dir_d   = 1'b1;
                        level_d = ONE;
                    end else begin
                        level_d = level_q - ONE;
                    end
                end
            end
        end else begin
            level_d = level_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= BOOT_MODE;
            arg_q    <= BOOT_ARG;
            tcnt_q   <= ZERO;
            bstate_q <= 1'b1;
            level_q  <= BOOT_LEVEL;
            dir_q    <= 1'b1;
        end else begin
            mode_q   <= mode_d;
            arg_q    <= arg_d;
            tcnt_q   <= tcnt_d;
            bstate_q <= bstate_d;
            level_q  <= level_d;
            dir_q    <= dir_d;
        end
    end

    assign lit = (level_q == MAX) || (level_q > pwm_cnt);

endmodule

// File: rtl/led_pattern_driver.sv
// Multi-channel LED driver top: shared tick prescaler and PWM counter,
// config-index decode, per-channel pattern engines and registered pins.
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int N_LED      = 6,
    parameter int TICK_DIV   = 27000,
    parameter int PWM_BITS   = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int BOOT_BLINK = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_idx,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_arg,
    output logic [N_LED-1:0]    led,
    output logic                tick_o
);

    localparam int               PCNT_W   = $clog2(TICK_DIV);
    localparam logic [N_LED-1:0] PIN_IDLE = {N_LED{ACTIVE_LOW != 0}};

    logic [PCNT_W-1:0]   pcnt_q,    pcnt_d;
    logic                tick_q,    tick_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N_LED-1:0]    led_q,     led_d;
    logic [N_LED-1:0]    lit_s;
    logic [N_LED-1:0]    wr_en_s;

    // Prescaler, PWM counter and pin polarity.
    always_comb begin
        tick_d    = (pcnt_q == PCNT_W'(TICK_DIV - 1));
        pcnt_d    = tick_d ? {PCNT_W{1'b0}} : (pcnt_q + PCNT_W'(1));
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        led_d     = lit_s ^ PIN_IDLE;
    end

    // Shared counters and output pin register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q    <= {PCNT_W{1'b0}};
            tick_q    <= 1'b0;
            pwm_cnt_q <= {PWM_BITS{1'b0}};
            led_q     <= PIN_IDLE;
        end else begin
            pcnt_q    <= pcnt_d;
            tick_q    <= tick_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        assign wr_en_s[i] = cfg_we && (cfg_idx == 4'(i));

        led_channel #(
            .PWM_BITS  (PWM_BITS),
            .BOOT_MODE ((BOOT_BLINK != 0) ? MODE_BLINK : MODE_OFF),
            .BOOT_ARG  (PWM_BITS'((BOOT_BLINK != 0) ? boot_arg(i, PWM_BITS) : 0))
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick_q),
            .wr_en   (wr_en_s[i]),
            .wr_mode (mode_t'(cfg_mode)),
            .wr_arg  (cfg_arg),
            .pwm_cnt (pwm_cnt_q),
            .lit     (lit_s[i])
        );
    end

    assign led    = led_q;
    assign tick_o = tick_q;

endmodule
